// File: rtl/pipeline_ex_mem.sv
// pipeline_ex_mem: execute stage with MEM/WB forwarding, ALU and the EX/MEM pipeline register
module pipeline_ex_mem #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   IDEX_A,
  input  logic [WIDTH-1:0]   IDEX_B,
  input  logic [WIDTH-1:0]   IDEX_Imm,
  input  logic [4:0]         IDEX_Shamt,
  input  logic [4:0]         IDEX_AddrC,
  input  logic [3:0]         IDEX_ALUFun,
  input  logic               IDEX_ALUSrc,
  input  logic [4:0]         IDEX_control,
  input  logic [1:0]         ForwardA,
  input  logic [1:0]         ForwardB,
  input  logic [WIDTH-1:0]   WB_data,
  input  logic               hold,
  input  logic               flush,
  output logic [2*WIDTH+4:0] EXMEM_data,
  output logic [4:0]         EXMEM_control,
  output logic               EXMEM_Ovf
);
  logic [WIDTH-1:0] fa, fb, opb, sum, diff, alu_out;
  logic             ovf;
  always_comb begin
    fa   = ForwardA == 2'b01 ? EXMEM_data[WIDTH-1:0] : ForwardA == 2'b10 ? WB_data : IDEX_A;
    fb   = ForwardB == 2'b01 ? EXMEM_data[WIDTH-1:0] : ForwardB == 2'b10 ? WB_data : IDEX_B;
    opb  = IDEX_ALUSrc ? IDEX_Imm : fb;
    sum  = fa + opb;
    diff = fa - opb;
    case (IDEX_ALUFun)
      4'd0:    alu_out = sum;
      4'd1:    alu_out = diff;
      4'd2:    alu_out = fa & opb;
      4'd3:    alu_out = fa | opb;
      4'd4:    alu_out = fa ^ opb;
      4'd5:    alu_out = ~(fa | opb);
      4'd6:    alu_out = opb << IDEX_Shamt;
      4'd7:    alu_out = opb >> IDEX_Shamt;
      4'd8:    alu_out = $signed(opb) >>> IDEX_Shamt;
      4'd9:    alu_out = {{(WIDTH-1){1'b0}}, $signed(fa) < $signed(opb)};
      4'd10:   alu_out = {{(WIDTH-1){1'b0}}, fa < opb};
      4'd11:   alu_out = {opb[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd12:   alu_out = opb << fa[4:0];
      4'd13:   alu_out = opb >> fa[4:0];
      4'd14:   alu_out = $signed(opb) >>> fa[4:0];
      default: alu_out = '0;
    endcase
    ovf = (IDEX_ALUFun == 4'd0 && fa[WIDTH-1] == opb[WIDTH-1] && sum[WIDTH-1] != fa[WIDTH-1]) ||
          (IDEX_ALUFun == 4'd1 && fa[WIDTH-1] != opb[WIDTH-1] && diff[WIDTH-1] != fa[WIDTH-1]);
  end
  // An overflowing instruction must not write memory or the register file
  always_ff @(posedge clk) begin
    if (!reset) begin
      EXMEM_data    <= '0;
      EXMEM_control <= '0;
      EXMEM_Ovf     <= 1'b0;
    end else if (flush) begin
      EXMEM_data    <= {IDEX_AddrC, fb, alu_out};
      EXMEM_control <= '0;
      EXMEM_Ovf     <= 1'b0;
    end else if (!hold) begin
      EXMEM_data    <= {IDEX_AddrC, fb, alu_out};
      EXMEM_control <= ovf ? IDEX_control & 5'b01011 : IDEX_control;
      EXMEM_Ovf     <= ovf;
    end
  end
endmodule

// File: tb/tb_pipeline_ex_mem.sv
// tb_pipeline_ex_mem: directed vectors with a queued scoreboard checked by an independent monitor
module tb_pipeline_ex_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IDEX_A, IDEX_B, IDEX_Imm, WB_data;
  logic [4:0]  IDEX_Shamt, IDEX_AddrC, IDEX_control;
  logic [3:0]  IDEX_ALUFun;
  logic        IDEX_ALUSrc, hold, flush;
  logic [1:0]  ForwardA, ForwardB;
  logic [68:0] EXMEM_data;
  logic [4:0]  EXMEM_control;
  logic        EXMEM_Ovf;

  typedef struct {
    logic [68:0] d;
    logic [4:0]  c;
    logic        o;
    logic [68:0] m;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   applied = 0;
  int   fails = 0;

  localparam logic [68:0] ALL = {69{1'b1}};

  pipeline_ex_mem dut (
    .clk(clk), .reset(reset),
    .IDEX_A(IDEX_A), .IDEX_B(IDEX_B), .IDEX_Imm(IDEX_Imm),
    .IDEX_Shamt(IDEX_Shamt), .IDEX_AddrC(IDEX_AddrC), .IDEX_ALUFun(IDEX_ALUFun),
    .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_control(IDEX_control),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .WB_data(WB_data),
    .hold(hold), .flush(flush),
    .EXMEM_data(EXMEM_data), .EXMEM_control(EXMEM_control), .EXMEM_Ovf(EXMEM_Ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [68:0] pk(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] r);
    return {a, wd, r};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      applied++;
      if ((EXMEM_data & e.m) !== (e.d & e.m) || EXMEM_control !== e.c || EXMEM_Ovf !== e.o) begin
        fails++;
        $display("FAIL %s: got data=%h ctrl=%b ovf=%b, expected data=%h ctrl=%b ovf=%b (data mask %h)",
                 e.nm, EXMEM_data, EXMEM_control, EXMEM_Ovf, e.d, e.c, e.o, e.m);
      end
    end
  end

  task automatic step(input logic [68:0] d, input logic [4:0] c, input logic o, input logic [68:0] m, input string nm);
    exp_t e;
    @(posedge clk);
    e.d = d; e.c = c; e.o = o; e.m = m; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b, input logic [4:0] addr, input logic [4:0] ctrl);
    IDEX_ALUFun = fun; IDEX_A = a; IDEX_B = b; IDEX_AddrC = addr; IDEX_control = ctrl;
  endtask

  task automatic rand_in();
    IDEX_A = $urandom; IDEX_B = $urandom; IDEX_Imm = $urandom; WB_data = $urandom;
    IDEX_Shamt = 5'($urandom); IDEX_AddrC = 5'($urandom); IDEX_control = 5'($urandom);
    IDEX_ALUFun = 4'($urandom); IDEX_ALUSrc = 1'($urandom);
    ForwardA = 2'($urandom); ForwardB = 2'($urandom);
    hold = 1'($urandom); flush = 1'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    rand_in();
    step('0, 5'b0, 1'b0, ALL, "reset_c1");
    rand_in();
    step('0, 5'b0, 1'b0, ALL, "reset_c2");
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    ForwardA = 2'b00; ForwardB = 2'b00; IDEX_ALUSrc = 1'b0; IDEX_Imm = 32'h0; IDEX_Shamt = 5'd0;
    set(4'd0, 32'd5, 32'd7, 5'd3, 5'b00100);
    step(pk(5'd3, 32'd7, 32'd12), 5'b00100, 1'b0, ALL, "first_add");

    IDEX_Shamt = 5'd4;
    set(4'd0,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h8000_0005), 5'b00100, 1'b0, ALL, "alu_add");
    set(4'd1,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h7FFF_FFFD), 5'b00000, 1'b1, ALL, "alu_sub_ovf");
    set(4'd2,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0000), 5'b00100, 1'b0, ALL, "alu_and");
    set(4'd3,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h8000_0005), 5'b00100, 1'b0, ALL, "alu_or");
    set(4'd4,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h8000_0005), 5'b00100, 1'b0, ALL, "alu_xor");
    set(4'd5,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h7FFF_FFFA), 5'b00100, 1'b0, ALL, "alu_nor");
    set(4'd6,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0040), 5'b00100, 1'b0, ALL, "alu_sll");
    set(4'd7,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0000), 5'b00100, 1'b0, ALL, "alu_srl");
    set(4'd9,  32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0001), 5'b00100, 1'b0, ALL, "alu_slt");
    set(4'd10, 32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0000), 5'b00100, 1'b0, ALL, "alu_sltu");
    set(4'd11, 32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0004_0000), 5'b00100, 1'b0, ALL, "alu_lui_reg");
    set(4'd12, 32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0008), 5'b00100, 1'b0, ALL, "alu_sllv");
    set(4'd13, 32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0002), 5'b00100, 1'b0, ALL, "alu_srlv");
    set(4'd14, 32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0002), 5'b00100, 1'b0, ALL, "alu_srav");
    set(4'd15, 32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h0000_0000), 5'b00100, 1'b0, ALL, "alu_zero");
    set(4'd8,  32'h8000_0001, 32'hF000_0000, 5'd1, 5'b00100); step(pk(5'd1, 32'hF000_0000, 32'hFF00_0000), 5'b00100, 1'b0, ALL, "alu_sra");
    set(4'd7,  32'h8000_0001, 32'hF000_0000, 5'd1, 5'b00100); step(pk(5'd1, 32'hF000_0000, 32'h0F00_0000), 5'b00100, 1'b0, ALL, "alu_srl_neg");
    IDEX_ALUSrc = 1'b1; IDEX_Imm = 32'h1234;
    set(4'd11, 32'h8000_0001, 32'h4, 5'd1, 5'b00100); step(pk(5'd1, 32'h4, 32'h1234_0000), 5'b00100, 1'b0, ALL, "alu_lui_imm");
    IDEX_ALUSrc = 1'b0;

    set(4'd0, 32'd2, 32'd3, 5'd1, 5'b00100); step(pk(5'd1, 32'd3, 32'd5), 5'b00100, 1'b0, ALL, "fwd_add");
    ForwardA = 2'b01;
    set(4'd1, 32'd99, 32'd1, 5'd2, 5'b00100); step(pk(5'd2, 32'd1, 32'd4), 5'b00100, 1'b0, ALL, "fwd_exmem_a");
    ForwardA = 2'b00; ForwardB = 2'b10; WB_data = 32'hAA; IDEX_ALUSrc = 1'b1; IDEX_Imm = 32'h10;
    set(4'd0, 32'd1, 32'd55, 5'd3, 5'b10000); step(pk(5'd3, 32'hAA, 32'h11), 5'b10000, 1'b0, ALL, "fwd_wb_b_imm");
    IDEX_ALUSrc = 1'b0;
    set(4'd0, 32'd1, 32'd55, 5'd3, 5'b00100); step(pk(5'd3, 32'hAA, 32'hAB), 5'b00100, 1'b0, ALL, "fwd_wb_b_reg");
    ForwardA = 2'b10; ForwardB = 2'b11;
    set(4'd1, 32'd9, 32'd10, 5'd4, 5'b00100); step(pk(5'd4, 32'd10, 32'hA0), 5'b00100, 1'b0, ALL, "fwd_wb_a");
    ForwardA = 2'b11; ForwardB = 2'b00;

    set(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd5, 5'b11111); step(pk(5'd5, 32'd1, 32'h8000_0000), 5'b01011, 1'b1, ALL, "ovf_add");
    ForwardA = 2'b00;
    set(4'd1, 32'h8000_0000, 32'd1, 5'd5, 5'b10110); step(pk(5'd5, 32'd1, 32'h7FFF_FFFF), 5'b00010, 1'b1, ALL, "ovf_sub");

    set(4'd0, 32'd10, 32'd20, 5'd2, 5'b00100); step(pk(5'd2, 32'd20, 32'd30), 5'b00100, 1'b0, ALL, "pre_hold");
    hold = 1'b1;
    set(4'd1, 32'd1, 32'd2, 5'd7, 5'b11000); step(pk(5'd2, 32'd20, 32'd30), 5'b00100, 1'b0, ALL, "hold_c1");
    set(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd8, 5'b00001); step(pk(5'd2, 32'd20, 32'd30), 5'b00100, 1'b0, ALL, "hold_c2");
    ForwardA = 2'b01;
    set(4'd3, 32'd0, 32'hF, 5'd9, 5'b00010); step(pk(5'd2, 32'd20, 32'd30), 5'b00100, 1'b0, ALL, "hold_c3_fwd");
    ForwardA = 2'b00; flush = 1'b1;
    set(4'd0, 32'd1, 32'd1, 5'd6, 5'b00100); step('0, 5'b0, 1'b0, '0, "hold_flush");
    hold = 1'b0; flush = 1'b0;
    set(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd6, 5'b11111); step(pk(5'd6, 32'd1, 32'h8000_0000), 5'b01011, 1'b1, ALL, "pre_flush_ovf");
    flush = 1'b1;
    step('0, 5'b0, 1'b0, '0, "flush_only");
    flush = 1'b0;
    set(4'd0, 32'd1, 32'd1, 5'd4, 5'b00100); step(pk(5'd4, 32'd1, 32'd2), 5'b00100, 1'b0, ALL, "resume");

    hold = 1'b1; reset = 1'b0;
    step('0, 5'b0, 1'b0, ALL, "reset_in_hold");
    reset = 1'b1;
    step('0, 5'b0, 1'b0, ALL, "hold_after_reset");
    hold = 1'b0;
    set(4'd4, 32'hFF, 32'h0F, 5'd9, 5'b01001); step(pk(5'd9, 32'h0F, 32'hF0), 5'b01001, 1'b0, ALL, "after_reset_xor");

    @(negedge clk);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
    $finish;
  end
endmodule
